mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter sharing one single-port, byte-addressed SRAM between instruction fetch (IF) and load/store (DM) in the unified-memory FRiscV configuration. Each cycle it selects at most one request, drives the SRAM port, and tags the access. It routes the read data returned one cycle later back to the owning requester with a valid pulse. It sits between the pc/instruction path, the ALU/data path and a single `sram_4k` instance.

## Interface
Parameters:
- `ARCH`, 32: data width in bits; `ARCH/8` byte enables.
- `ADDR_WIDTH`, 12: byte address width at the SRAM.
- `MAX_WAIT`, 4: consecutive lost cycles before IF is forced a grant (fixed-priority build only); range 1–15.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk` in, 1: rising-edge clock.
  - `rst` in, 1: asynchronous, active-high reset.
- Instruction fetch port:
  - `if_req_in` in, 1: IF read request.
  - `if_addr_in` in, ADDR_WIDTH: IF byte address.
  - `if_gnt_out` out, 1: IF request accepted this cycle.
  - `if_rvalid_out` out, 1: IF read data valid.
  - `if_rdata_out` out, ARCH: IF read data.
- Load/store port:
  - `dm_req_in` in, 1: DM request.
  - `dm_we_in` in, 1: 1 = write, 0 = read.
  - `dm_be_in` in, ARCH/8: byte enables for writes.
  - `dm_addr_in` in, ADDR_WIDTH: DM byte address.
  - `dm_wdata_in` in, ARCH: write data.
  - `dm_gnt_out` out, 1: DM request accepted this cycle.
  - `dm_rvalid_out` out, 1: DM read data valid.
  - `dm_rdata_out` out, ARCH: DM read data.
- SRAM port:
  - `mem_addr_out` out, ADDR_WIDTH: SRAM byte address.
  - `mem_we_out` out, 1: SRAM write strobe.
  - `mem_be_out` out, ARCH/8: SRAM byte enables.
  - `mem_wdata_out` out, ARCH: SRAM write data.
  - `mem_rdata_in` in, ARCH: SRAM read data, valid one cycle after the address.

## Operation
- Handshake: a requester holds `*_req_in` and its payload stable until `*_gnt_out` = 1. The grant is combinational in the same cycle, and the SRAM sees the winning payload in that cycle.
- Exactly one grant or none per cycle. With no request, the SRAM port is driven as: `mem_we_out`=0, `mem_be_out`=0, address and write data = 0.
- IF accesses are always reads. A DM write drives `mem_we_out`=1 and `mem_be_out`=`dm_be_in`. A DM read drives `mem_be_out`=0.
- Response tag register `rsp_q` takes one of three values: NONE, IF or DM. It is loaded each cycle with the owner of any granted read, or NONE when there is no read grant.
- `if_rvalid_out`=1 when `rsp_q`=IF, and `if_rdata_out`=`mem_rdata_in` in that case, else 0. The same rule applies to the DM outputs with `rsp_q`=DM.
- Writes never produce rvalid.
- Back-to-back reads are fully pipelined: a new grant is allowed in the same cycle as a response.
- Arbitration state `last_q` (IF/DM) records the winner of the most recent contended cycle (both requests high).
- With only one requester active, it is granted immediately regardless of `last_q`.

## Timing
- Grant latency 0 cycles. Read data latency 1 cycle after grant.
- Reset values: `rsp_q`=NONE, `last_q`=IF, `wait_q`=0. All rvalid outputs are 0 and both rdata outputs are 0.
- Reset asserted while a read is outstanding: the response is dropped, and no rvalid appears after reset is released.
- Requests may be withdrawn before grant without side effects, and no state changes in that case.
- Simultaneous requests are resolved per the Configuration section.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - On contention the requester not equal to `last_q` wins, and `last_q` is then updated.
  - `wait_q` is not implemented.
- `MEM_ARB_RR_EN` undefined: fixed priority, with DM winning contention.
  - Counter `wait_q` (4 bits) increments each cycle `if_req_in`=1 and IF is not granted, saturating at 15. It clears when IF is granted or when `if_req_in`=0.
  - When `wait_q`=`MAX_WAIT`, IF wins the next contention.

## Structure
- A shared package holds:
  - `rsp_owner_e` enum (NONE/IF/DM).
  - Defaults `MEM_ARB_ADDR_WIDTH`=12 and `MEM_ARB_MAX_WAIT`=4.
- No sub-module: the arbiter and response routing live in one module.

## Test plan
- IF read only at `0x010`: `if_gnt_out`=1 in the same cycle, `mem_addr_out`=`0x010`. Next cycle `if_rvalid_out`=1 and `if_rdata_out` equals the word preloaded at `0x010`.
- DM write `0xDEADBEEF`, `be`=`4'b0011`, at `0x020`, then DM read at `0x020`: the write gives no rvalid. The read returns `0x0000BEEF` over an initial `0x00000000`.
- Both ports requesting for 6 cycles, RR build: grants alternate DM, IF, DM, IF… starting with DM, since `last_q`=IF after reset. Each rvalid returns to the correct port.
- Both ports requesting continuously, fixed build with `MAX_WAIT`=4: DM is granted for 4 cycles, then IF on the 5th, then the pattern repeats.
- Interleaved back-to-back reads (IF `0x000`, DM `0x100`, IF `0x004`): one rvalid per cycle on alternating ports, with no bubbles.
- `rst` asserted in the cycle after a DM read grant: `dm_rvalid_out` stays 0, and after release all outputs match their reset values.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_pkg
//  Description : Shared types and defaults for the IF/DM unified-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_DM   = 2'd2
    } rsp_owner_e;

    typedef enum logic {
        ARB_IF = 1'b0,
        ARB_DM = 1'b1
    } arb_owner_e;

    localparam int MEM_ARB_ADDR_WIDTH = 12;
    localparam int MEM_ARB_MAX_WAIT   = 4;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one single-port SRAM between instruction fetch (IF) and
//                load/store (DM); routes 1-cycle read data back to the owner.
//                Define MEM_ARB_RR_EN for round-robin, else fixed DM priority
//                with an IF starvation counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ARCH       = 32,
    parameter int ADDR_WIDTH = MEM_ARB_ADDR_WIDTH,
    parameter int MAX_WAIT   = MEM_ARB_MAX_WAIT
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_req_in,
    input  logic [ADDR_WIDTH-1:0] if_addr_in,
    output logic                  if_gnt_out,
    output logic                  if_rvalid_out,
    output logic [ARCH-1:0]       if_rdata_out,

    input  logic                  dm_req_in,
    input  logic                  dm_we_in,
    input  logic [ARCH/8-1:0]     dm_be_in,
    input  logic [ADDR_WIDTH-1:0] dm_addr_in,
    input  logic [ARCH-1:0]       dm_wdata_in,
    output logic                  dm_gnt_out,
    output logic                  dm_rvalid_out,
    output logic [ARCH-1:0]       dm_rdata_out,

    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    output logic                  mem_we_out,
    output logic [ARCH/8-1:0]     mem_be_out,
    output logic [ARCH-1:0]       mem_wdata_out,
    input  logic [ARCH-1:0]       mem_rdata_in
);

    rsp_owner_e rsp_q, rsp_d;
    arb_owner_e last_q, last_d;

    logic w_contend;
    logic w_if_pri;
    logic w_if_gnt;
    logic w_dm_gnt;

    assign w_contend = if_req_in & dm_req_in;

`ifdef MEM_ARB_RR_EN
    // Round-robin: on contention the side that did not win last time goes.
    assign w_if_pri = (last_q == ARB_DM);
`else
    localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

    logic [3:0] wait_q, wait_d;

    assign w_if_pri = (wait_q == c_max_wait);

    always_comb begin
        wait_d = wait_q;
        if (!if_req_in || w_if_gnt) begin
            wait_d = 4'd0;
        end else if (wait_q != 4'hF) begin
            wait_d = wait_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= 4'd0;
        end else begin
            wait_q <= wait_d;
        end
    end
`endif

    assign w_if_gnt = if_req_in & (~dm_req_in | w_if_pri);
    assign w_dm_gnt = dm_req_in & ~w_if_gnt;

    assign if_gnt_out = w_if_gnt;
    assign dm_gnt_out = w_dm_gnt;

    always_comb begin
        mem_addr_out  = '0;
        mem_we_out    = 1'b0;
        mem_be_out    = '0;
        mem_wdata_out = '0;
        if (w_if_gnt) begin
            mem_addr_out = if_addr_in;
        end else if (w_dm_gnt) begin
            mem_addr_out = dm_addr_in;
            if (dm_we_in) begin
                mem_we_out    = 1'b1;
                mem_be_out    = dm_be_in;
                mem_wdata_out = dm_wdata_in;
            end
        end
    end

    always_comb begin
        rsp_d = RSP_NONE;
        if (w_if_gnt) begin
            rsp_d = RSP_IF;
        end else if (w_dm_gnt && !dm_we_in) begin
            rsp_d = RSP_DM;
        end
    end

    always_comb begin
        last_d = last_q;
        if (w_contend) begin
            last_d = w_if_gnt ? ARB_IF : ARB_DM;
        end
    end

    // Async reset clears the tag, so an in-flight read never surfaces.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_q  <= RSP_NONE;
            last_q <= ARB_IF;
        end else begin
            rsp_q  <= rsp_d;
            last_q <= last_d;
        end
    end

    assign if_rvalid_out = (rsp_q == RSP_IF);
    assign dm_rvalid_out = (rsp_q == RSP_DM);
    assign if_rdata_out  = (rsp_q == RSP_IF) ? mem_rdata_in : '0;
    assign dm_rdata_out  = (rsp_q == RSP_DM) ? mem_rdata_in : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter with a 4 KB
//                byte-enabled SRAM model (1-cycle read latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_gnt, if_rvalid;
    logic [11:0] if_addr;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [3:0]  dm_be;
    logic [11:0] dm_addr;
    logic [31:0] dm_wdata, dm_rdata;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] sram [0:1023];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ARCH(32), .ADDR_WIDTH(12), .MAX_WAIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_in    (if_req),
        .if_addr_in   (if_addr),
        .if_gnt_out   (if_gnt),
        .if_rvalid_out(if_rvalid),
        .if_rdata_out (if_rdata),
        .dm_req_in    (dm_req),
        .dm_we_in     (dm_we),
        .dm_be_in     (dm_be),
        .dm_addr_in   (dm_addr),
        .dm_wdata_in  (dm_wdata),
        .dm_gnt_out   (dm_gnt),
        .dm_rvalid_out(dm_rvalid),
        .dm_rdata_out (dm_rdata),
        .mem_addr_out (mem_addr),
        .mem_we_out   (mem_we),
        .mem_be_out   (mem_be),
        .mem_wdata_out(mem_wdata),
        .mem_rdata_in (mem_rdata)
    );

    // SRAM model: preset contents loaded while rst is high.
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 1024; k++) sram[k] <= 32'h0;
            sram[0]  <= 32'hA0A0A0A0;
            sram[1]  <= 32'hC2C2C2C2;
            sram[4]  <= 32'h11112222;
            sram[64] <= 32'hB1B1B1B1;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) sram[mem_addr[11:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
        mem_rdata <= sram[mem_addr[11:2]];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_if_rvalid"}, {31'b0, if_rvalid}, 32'd0);
        check_eq({tag, "_dm_rvalid"}, {31'b0, dm_rvalid}, 32'd0);
        check_eq({tag, "_if_rdata"},  if_rdata, 32'd0);
        check_eq({tag, "_dm_rdata"},  dm_rdata, 32'd0);
        check_eq({tag, "_mem_we"},    {31'b0, mem_we}, 32'd0);
        check_eq({tag, "_mem_be"},    {28'b0, mem_be}, 32'd0);
        check_eq({tag, "_mem_addr"},  {20'b0, mem_addr}, 32'd0);
    endtask

    function automatic logic exp_if_win(input int i);
`ifdef MEM_ARB_RR_EN
        return (i % 2) == 1;
`else
        return (i % 5) == 4;
`endif
    endfunction

    // Both ports contend for n cycles; checks grant order and response routing.
    task automatic contend(input string tag, input int n, input bit rr_order);
        logic prev_if;
        logic e;
        prev_if = 1'b0;
        if_req = 1'b1; if_addr = 12'h000;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h100;
        for (int i = 0; i < n; i++) begin
            e = rr_order ? exp_if_win(i) : ((i % 5) == 4);
            @(negedge clk);
            check_eq({tag, "_if_gnt"}, {31'b0, if_gnt}, {31'b0, e});
            check_eq({tag, "_dm_gnt"}, {31'b0, dm_gnt}, {31'b0, ~e});
            if (i > 0) begin
                check_eq({tag, "_if_rvalid"}, {31'b0, if_rvalid}, {31'b0, prev_if});
                check_eq({tag, "_dm_rvalid"}, {31'b0, dm_rvalid}, {31'b0, ~prev_if});
                if (prev_if) check_eq({tag, "_if_rdata"}, if_rdata, 32'hA0A0A0A0);
                else         check_eq({tag, "_dm_rdata"}, dm_rdata, 32'hB1B1B1B1);
            end
            prev_if = e;
            cyc();
        end
        idle();
        @(negedge clk);
        check_eq({tag, "_last_if_rvalid"}, {31'b0, if_rvalid}, {31'b0, prev_if});
        check_eq({tag, "_last_dm_rvalid"}, {31'b0, dm_rvalid}, {31'b0, ~prev_if});
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        check_eq("reset_if_gnt", {31'b0, if_gnt}, 32'd0);
        check_eq("reset_dm_gnt", {31'b0, dm_gnt}, 32'd0);
        cyc();
        rst = 1'b0;
        cyc();

        // IF read at 0x010
        if_req = 1'b1; if_addr = 12'h010;
        @(negedge clk);
        check_eq("ifrd_gnt",  {31'b0, if_gnt}, 32'd1);
        check_eq("ifrd_dm_gnt", {31'b0, dm_gnt}, 32'd0);
        check_eq("ifrd_addr", {20'b0, mem_addr}, 32'h010);
        check_eq("ifrd_we",   {31'b0, mem_we}, 32'd0);
        cyc();
        idle();
        @(negedge clk);
        check_eq("ifrd_rvalid", {31'b0, if_rvalid}, 32'd1);
        check_eq("ifrd_rdata",  if_rdata, 32'h11112222);
        check_eq("ifrd_dm_rvalid", {31'b0, dm_rvalid}, 32'd0);
        cyc();

        // DM partial write then read-back at 0x020
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 12'h020; dm_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check_eq("dmwr_gnt",   {31'b0, dm_gnt}, 32'd1);
        check_eq("dmwr_we",    {31'b0, mem_we}, 32'd1);
        check_eq("dmwr_be",    {28'b0, mem_be}, 32'h3);
        check_eq("dmwr_wdata", mem_wdata, 32'hDEADBEEF);
        check_eq("dmwr_addr",  {20'b0, mem_addr}, 32'h020);
        cyc();
        dm_we = 1'b0; dm_be = 4'b0000; dm_wdata = '0;
        @(negedge clk);
        check_eq("dmwr_no_rvalid", {31'b0, dm_rvalid}, 32'd0);
        check_eq("dmrd_gnt", {31'b0, dm_gnt}, 32'd1);
        check_eq("dmrd_be",  {28'b0, mem_be}, 32'h0);
        check_eq("dmrd_we",  {31'b0, mem_we}, 32'd0);
        cyc();
        idle();
        @(negedge clk);
        check_eq("dmrd_rvalid", {31'b0, dm_rvalid}, 32'd1);
        check_eq("dmrd_rdata",  dm_rdata, 32'h0000BEEF);
        check_eq("dmrd_if_rvalid", {31'b0, if_rvalid}, 32'd0);
        cyc();

`ifndef MEM_ARB_RR_EN
        // Fixed priority with MAX_WAIT=4: DM x4, IF, repeat
        contend("fixed", 10, 1'b0);
`endif

        // Back-to-back interleaved reads
        if_req = 1'b1; if_addr = 12'h000;
        @(negedge clk);
        check_eq("b2b_a_gnt", {31'b0, if_gnt}, 32'd1);
        cyc();
        idle();
        dm_req = 1'b1; dm_addr = 12'h100;
        @(negedge clk);
        check_eq("b2b_b_gnt",    {31'b0, dm_gnt}, 32'd1);
        check_eq("b2b_b_rvalid", {31'b0, if_rvalid}, 32'd1);
        check_eq("b2b_b_rdata",  if_rdata, 32'hA0A0A0A0);
        cyc();
        idle();
        if_req = 1'b1; if_addr = 12'h004;
        @(negedge clk);
        check_eq("b2b_c_gnt",    {31'b0, if_gnt}, 32'd1);
        check_eq("b2b_c_rvalid", {31'b0, dm_rvalid}, 32'd1);
        check_eq("b2b_c_rdata",  dm_rdata, 32'hB1B1B1B1);
        check_eq("b2b_c_if_rv",  {31'b0, if_rvalid}, 32'd0);
        cyc();
        idle();
        @(negedge clk);
        check_eq("b2b_d_rvalid", {31'b0, if_rvalid}, 32'd1);
        check_eq("b2b_d_rdata",  if_rdata, 32'hC2C2C2C2);
        check_eq("b2b_d_dm_rv",  {31'b0, dm_rvalid}, 32'd0);
        cyc();
        @(negedge clk);
        check_eq("b2b_e_if_rv", {31'b0, if_rvalid}, 32'd0);
        check_eq("b2b_e_dm_rv", {31'b0, dm_rvalid}, 32'd0);
        cyc();

        // Reset the cycle after a DM read grant
        dm_req = 1'b1; dm_addr = 12'h100;
        @(negedge clk);
        check_eq("rstrd_gnt", {31'b0, dm_gnt}, 32'd1);
        cyc();
        idle();
        rst = 1'b1;
        @(negedge clk);
        check_eq("rstrd_dm_rvalid", {31'b0, dm_rvalid}, 32'd0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check_quiet("rstrd_post");
        cyc();

        // After reset last_q=IF: RR alternates from DM; fixed gives DM x4 then IF
`ifdef MEM_ARB_RR_EN
        contend("rr", 6, 1'b1);
`else
        contend("postrst", 5, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
